tick_rate_ctrl: RTL
===================

// Module: tick_rate_ctrl
// PURPOSE
//   Rate controller for the lab's selectable tick/clock-divider path: one prescaler, four divide ratios.
//   Requesters change the rate via req/ack handshake; the switch is applied only at a prescaler wrap,
//   so tick/out never shows a runt or stretched period. Sits between FSM/UI logic and blink/scan consumers.
// PARAMETERS
//   BITS_0       5  log2 divide ratio for code 2'b00 (period 32); must be the largest BITS_n
//   BITS_1       4  log2 divide ratio for code 2'b01 (period 16)
//   BITS_2       3  log2 divide ratio for code 2'b10 (period 8)
//   BITS_3       2  log2 divide ratio for code 2'b11 (period 4)
//   SWEEP_TICKS  8  ticks per step in sweep mode (TICK_SWEEP_EN only), >=1
// PORTS
//   CLK          in   1  system clock; all logic on rising edge
//   reset        in   1  asynchronous, active-high reset
//   enable       in   1  1: prescaler runs; 0: prescaler held at 0
//   req          in   1  rate-change request (level)
//   req_frec     in   2  requested rate code, sampled when req accepted
//   sweep_en     in   1  auto-sweep enable (ignored unless TICK_SWEEP_EN)
//   ack          out  1  one-cycle pulse: requested rate now active
//   busy         out  1  1 while a change is pending (PEND)
//   frec_active  out  2  rate code currently driving the prescaler
//   tick         out  1  one-cycle pulse on terminal count
//   out          out  1  registered 50% square wave, period 2^BITS_sel
// BEHAVIOUR
//   Reset (async, immediate): count=0, frec_active=2'b00, state=IDLE, ack=0, busy=0, tick=0, out=0.
//   Prescaler: BITS_0-wide count; TERM = 2^BITS_sel-1 (sel = frec_active). enable=1: count==TERM -> 0,
//     else +1. enable=0: count<=0. tick = enable && count==TERM (comb. from regs). out is a flop loaded with
//     bit (BITS_sel-1) of next count, so it changes on the same edge as count; out=0 whenever count=0.
//   FSM states IDLE, PEND, ACK, WAIT_LOW (encodings in shared header):
//     IDLE:     req=1 -> latch req_frec into pend_frec, -> PEND.
//     PEND:     busy=1. enable=1 && count==TERM -> frec_active<=pend_frec, count<=0, -> ACK.
//               enable=0 -> frec_active<=pend_frec next edge, -> ACK (no output activity, glitch-free).
//     ACK:      ack=1 for exactly this cycle; -> WAIT_LOW.
//     WAIT_LOW: req=0 -> IDLE; req held high never causes a second ack.
//   Latency: ack in the cycle after the wrap edge (count=0 at new rate); worst case 2^BITS_sel(old)+1 cycles.
//   Request equal to current code: full handshake anyway, period unchanged.
//   req_frec changes while PEND: ignored (pend_frec already latched).
//   enable deasserted mid-PEND: switch completes per enable=0 rule; enable re-asserted: count restarts at 0.
//   Reset mid-PEND: pending request discarded, no ack.
// CONFIGURATION
//   TICK_SWEEP_EN defined: in IDLE with sweep_en=1 and req=0, an internal tick counter (clears on
//     sweep_en=0 or leaving IDLE) issues an internal request for frec_active+1 (3 wraps to 0) after
//     SWEEP_TICKS ticks; goes through PEND like an external request but ACK state skips ack pulse.
//     External req in IDLE has priority over sweep in the same cycle.
//   TICK_SWEEP_EN undefined: sweep counter and logic absent; sweep_en port kept, unused; rate changes
//     only via req.
// STRUCTURE
//   Shared header tick_rate_defs.vh: FSM state encodings, rate codes FREC_0..FREC_3, default BITS_n values.
//   Sub-module tick_prescaler: count register, TERM select, tick and out flop; controller owns FSM/pend regs.
// TESTING
//   1. reset, enable=1, no req -> tick every 32 cycles; out 16 high/16 low; frec_active=00.
//   2. req=1, req_frec=11 at count=5 -> busy 1 till count=31 edge; ack one cycle at count=0; then tick every 4.
//   3. frec_active=01, enable=0, req 10 -> ack 2 cycles after req; out=0, tick=0 throughout; enable=1 -> period 8.
//   4. reset pulse while PEND -> same cycle: count=0, busy=0, frec_active=00; no ack after release.
//   5. req held high 100 cycles after ack -> exactly one ack; drop then raise req -> second handshake.
//   6. TICK_SWEEP_EN, sweep_en=1, defaults -> frec_active 00->01 after 8 ticks (256+ cycles), ack stays 0.

Source files
------------

// File: rtl/tick_rate_ctrl_pkg.sv
// tick_rate_ctrl_pkg
//   Shared definitions for the tick rate controller: FSM state encodings,
//   rate codes, default divide widths and a small helper for the sweep path.
//   Configuration macro: TICK_SWEEP_EN (see tick_rate_ctrl.sv).
package tick_rate_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [1:0] FREC_0 = 2'b00;
  localparam logic [1:0] FREC_1 = 2'b01;
  localparam logic [1:0] FREC_2 = 2'b10;
  localparam logic [1:0] FREC_3 = 2'b11;

  localparam int BITS_0_DEF      = 5;
  localparam int BITS_1_DEF      = 4;
  localparam int BITS_2_DEF      = 3;
  localparam int BITS_3_DEF      = 2;
  localparam int SWEEP_TICKS_DEF = 8;

  // Sweep steps through the codes in order; code 3 wraps back to code 0.
  function automatic logic [1:0] frec_next(input logic [1:0] frec);
    return frec + 2'd1;
  endfunction

endpackage

// File: rtl/tick_rate_ctrl_if.sv
// tick_rate_ctrl_if
//   Request/status bundle between a rate requester (master) and the tick rate
//   controller (slave).
//   enable      : prescaler run enable
//   req         : rate change request level
//   req_frec    : requested rate code
//   sweep_en    : auto-sweep enable (only meaningful with TICK_SWEEP_EN)
//   ack         : one-cycle pulse, requested rate now active
//   busy        : change pending
//   frec_active : rate code driving the prescaler
//   tick        : one-cycle terminal count pulse
//   out         : 50% square wave
interface tick_rate_ctrl_if;
  logic       enable;
  logic       req;
  logic [1:0] req_frec;
  logic       sweep_en;
  logic       ack;
  logic       busy;
  logic [1:0] frec_active;
  logic       tick;
  logic       out;

  modport master (
    output enable, req, req_frec, sweep_en,
    input  ack, busy, frec_active, tick, out
  );

  modport slave (
    input  enable, req, req_frec, sweep_en,
    output ack, busy, frec_active, tick, out
  );
endinterface

// File: rtl/tick_rate_ctrl_prescaler.sv
// tick_rate_ctrl_prescaler
//   Shared prescaler for all four rates. Count is BITS_0 wide; the terminal
//   count and the square wave bit follow the selected rate code.
//   clk, rst : clock, async active-high reset
//   enable   : 1 runs the counter, 0 holds it at zero
//   frec     : active rate code
//   tick     : enable && count at terminal (combinational from registers)
//   out      : registered square wave, 0 whenever count is 0
module tick_rate_ctrl_prescaler #(
  parameter int BITS_0 = 5,
  parameter int BITS_1 = 4,
  parameter int BITS_2 = 3,
  parameter int BITS_3 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] frec,
  output logic       tick,
  output logic       out
);

  localparam int CW = BITS_0;
  localparam logic [CW-1:0] TERM_0 = CW'((1 << BITS_0) - 1);
  localparam logic [CW-1:0] TERM_1 = CW'((1 << BITS_1) - 1);
  localparam logic [CW-1:0] TERM_2 = CW'((1 << BITS_2) - 1);
  localparam logic [CW-1:0] TERM_3 = CW'((1 << BITS_3) - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] term;
  logic [CW-1:0] next_cnt;
  logic          next_out;
  logic          at_term;

  always_comb begin
    term = TERM_0;
    case (frec)
      2'b00:   term = TERM_0;
      2'b01:   term = TERM_1;
      2'b10:   term = TERM_2;
      default: term = TERM_3;
    endcase
  end

  assign at_term = (count == term);
  assign tick    = enable && at_term;

  always_comb begin
    next_cnt = '0;
    if (enable && !at_term) next_cnt = count + CW'(1);
  end

  // The wave is the top bit of the selected period, taken from the next count
  // so it moves on the same edge as the counter.
  always_comb begin
    next_out = 1'b0;
    case (frec)
      2'b00:   next_out = next_cnt[BITS_0-1];
      2'b01:   next_out = next_cnt[BITS_1-1];
      2'b10:   next_out = next_cnt[BITS_2-1];
      default: next_out = next_cnt[BITS_3-1];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      out   <= 1'b0;
    end else begin
      count <= next_cnt;
      out   <= next_out;
    end
  end

endmodule

// File: rtl/tick_rate_ctrl.sv
// tick_rate_ctrl
//   Rate controller for the tick/clock-divider path. A request is latched and
//   applied only at a prescaler wrap (or immediately while the prescaler is
//   stopped), so tick/out never produce a runt or stretched period.
//   clk, rst : clock, async active-high reset
//   bus      : tick_rate_ctrl_if.slave (request, status, tick and out)
//   Macro TICK_SWEEP_EN: when defined, an idle controller with sweep_en=1
//   steps to the next rate code every SWEEP_TICKS ticks without pulsing ack.
//   When undefined the sweep logic is absent and sweep_en is ignored.
//
//   state    | meaning
//   IDLE     | no change pending, waiting for req (or sweep)
//   PEND     | request latched, waiting for wrap or stopped prescaler
//   ACK      | new rate active, ack pulses here (external requests only)
//   WAIT_LOW | waiting for req to drop before accepting another
module tick_rate_ctrl
  import tick_rate_ctrl_pkg::*;
#(
  parameter int BITS_0      = BITS_0_DEF,
  parameter int BITS_1      = BITS_1_DEF,
  parameter int BITS_2      = BITS_2_DEF,
  parameter int BITS_3      = BITS_3_DEF,
  parameter int SWEEP_TICKS = SWEEP_TICKS_DEF
) (
  input logic             clk,
  input logic             rst,
  tick_rate_ctrl_if.slave bus
);

  state_t     state;
  logic [1:0] pend_frec;
  logic [1:0] frec_active;
  logic       ack;
  logic       busy;
  logic       sweep_req;
  logic       sweep_fire;
  logic       tick;
  logic       out;

  tick_rate_ctrl_prescaler #(
    .BITS_0 (BITS_0),
    .BITS_1 (BITS_1),
    .BITS_2 (BITS_2),
    .BITS_3 (BITS_3)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.enable),
    .frec   (frec_active),
    .tick   (tick),
    .out    (out)
  );

`ifdef TICK_SWEEP_EN
  localparam int SW = $clog2(SWEEP_TICKS + 1);
  logic [SW-1:0] sweep_cnt;

  assign sweep_fire = (state == IDLE) && bus.sweep_en && !bus.req &&
                      tick && (sweep_cnt == '0);

  // Down-counter of remaining ticks; reloads whenever sweeping is not live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= SW'(SWEEP_TICKS - 1);
    end else if ((state != IDLE) || !bus.sweep_en || bus.req || sweep_fire) begin
      sweep_cnt <= SW'(SWEEP_TICKS - 1);
    end else if (tick) begin
      sweep_cnt <= sweep_cnt - SW'(1);
    end
  end
`else
  assign sweep_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_frec   <= FREC_0;
      frec_active <= FREC_0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      sweep_req   <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            pend_frec <= bus.req_frec;
            sweep_req <= 1'b0;
            busy      <= 1'b1;
            state     <= PEND;
          end else if (sweep_fire) begin
            pend_frec <= frec_next(frec_active);
            sweep_req <= 1'b1;
            busy      <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          // tick marks the wrap edge; a stopped prescaler is already at zero.
          if (!bus.enable || tick) begin
            frec_active <= pend_frec;
            busy        <= 1'b0;
            ack         <= !sweep_req;
            state       <= ACK;
          end
        end
        ACK: begin
          state <= WAIT_LOW;
        end
        default: begin
          if (!bus.req) state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = ack;
  assign bus.busy        = busy;
  assign bus.frec_active = frec_active;
  assign bus.tick        = tick;
  assign bus.out         = out;

endmodule
